// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// sram_arb_pkg
// ----------------------------------------------------------------------------
// Shared types and helpers for the three-master SRAM arbiter.
//   - state_t      : arbiter state encoding
//   - SLOT_*       : time-slot identifiers (scan / CPU)
//   - lane ranges  : VRAM lane is word[47:32], RAM lane is word[31:0]
//   - lane_merge   : builds the read-modify-write word for a CPU lane write
//   - lane_extract : returns a CPU read lane (VRAM lane zero-extended)
// Revision: 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  localparam int WORD_W  = 48;
  localparam int VRAM_HI = 47;
  localparam int VRAM_LO = 32;
  localparam int VRAM_W  = 16;
  localparam int RAM_HI  = 31;
  localparam int RAM_LO  = 0;
  localparam int RAM_W   = 32;

  localparam logic SLOT_SCAN = 1'b0;
  localparam logic SLOT_CPU  = 1'b1;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_READ   = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_ACK    = 3'd5
  } state_t;

  // Replace one lane of old_word with CPU write data, keeping the other lane.
  function automatic logic [WORD_W-1:0] lane_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [RAM_W-1:0]  wdata,
    input logic              sel_ram
  );
    if (sel_ram) begin
      return {old_word[VRAM_HI:VRAM_LO], wdata};
    end
    return {wdata[VRAM_W-1:0], old_word[RAM_HI:RAM_LO]};
  endfunction

  // Pick the CPU-visible lane of a word; the VRAM lane is zero-extended.
  function automatic logic [RAM_W-1:0] lane_extract(
    input logic [WORD_W-1:0] word,
    input logic              sel_ram
  );
    if (sel_ram) begin
      return word[RAM_HI:RAM_LO];
    end
    return {{(RAM_W-VRAM_W){1'b0}}, word[VRAM_HI:VRAM_LO]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_loader.sv
`default_nettype none
// ============================================================================
// sram_init_loader
// ----------------------------------------------------------------------------
// Power-up copier: streams INIT_WORDS words from a 1-cycle-latency ROM into
// SRAM. Counter c addresses the ROM; the word returned for c-1 is written to
// SRAM address c-1 in the cycle where the counter reads c.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   rom_addr    : ROM address (= c)
//   rom_data    : ROM data, valid one cycle after rom_addr
//   init_we     : SRAM write strobe request for this cycle
//   init_addr   : SRAM write address (= c-1)
//   init_wdata  : SRAM write data (= rom_data)
//   init_last   : this cycle carries the final write
//   init_done   : registered, high once the copy has finished
// Revision: 1.0 - initial release
// ============================================================================
module sram_init_loader #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 48,
  parameter int INIT_WORDS = 307200
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_wdata,
  output logic              init_last,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(INIT_WORDS);

  logic [ADDR_W-1:0] c;

  // c stops at INIT_WORDS so it never runs past the image.
  always_ff @(posedge clk) begin
    if (rst) begin
      c         <= '0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      if (c == LAST_C) begin
        init_done <= 1'b1;
      end else begin
        c <= c + ADDR_W'(1);
      end
    end
  end

  assign rom_addr   = c;
  assign init_we    = !init_done && (c != '0);
  assign init_addr  = c - ADDR_W'(1);
  assign init_wdata = rom_data;
  assign init_last  = !init_done && (c == LAST_C);

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// sram_arbiter
// ----------------------------------------------------------------------------
// Time-slotted controller sharing one 48-bit asynchronous SRAM between the
// power-up loader, the VGA scan port (VRAM lane [47:32]) and the CPU port
// (RAM lane [31:0] or VRAM lane). After init, cycles alternate scan / CPU.
// CPU writes are read-modify-write so the untouched lane is preserved.
// Ports:
//   clk_50mhz, rst         : clock, synchronous active-high reset
//   cpu_req/we/sel_ram     : CPU request, held until cpu_ready
//   cpu_addr, cpu_wdata    : CPU address / write data (sampled at accept)
//   cpu_rdata, cpu_ready   : CPU read data, one-cycle completion pulse
//   scan_addr              : VGA scan address (used during scan slots)
//   scan_data, scan_valid  : last scan VRAM lane and its update pulse
//   rom_addr, rom_data     : init ROM interface (1-cycle latency)
//   init_done              : loader finished
//   sram_*                 : SRAM pins; DQ tristate lives in the top level
// Revision: 1.0 - initial release
// ============================================================================
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 48,
  parameter int INIT_WORDS = 307200
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_sel_ram,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [15:0]       scan_data,
  output logic              scan_valid,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_drive,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  state_t            state;
  logic              slot;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_sel;
  logic [31:0]       lat_wdata;
  logic [DATA_W-1:0] merge_word;

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_wdata;
  logic              init_last;

  sram_init_loader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .INIT_WORDS (INIT_WORDS)
  ) u_loader (
    .clk        (clk_50mhz),
    .rst        (rst),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .init_we    (init_we),
    .init_addr  (init_addr),
    .init_wdata (init_wdata),
    .init_last  (init_last),
    .init_done  (init_done)
  );

  // --------------------------------------------------------------------------
  // Control FSM and registered outputs. The SRAM is asynchronous, so every
  // access completes within its slot and read data is captured at the edge
  // that ends the slot.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state      <= ST_INIT;
      slot       <= SLOT_SCAN;
      lat_addr   <= '0;
      lat_sel    <= 1'b0;
      lat_wdata  <= '0;
      merge_word <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      scan_data  <= '0;
      scan_valid <= 1'b0;
    end else begin
      cpu_ready  <= 1'b0;
      scan_valid <= 1'b0;

      // Slot stays on scan through init so the first post-init cycle is scan.
      if (state == ST_INIT) begin
        slot <= SLOT_SCAN;
      end else begin
        slot <= ~slot;
      end

      if ((state != ST_INIT) && (slot == SLOT_SCAN)) begin
        scan_data  <= sram_rdata[VRAM_HI:VRAM_LO];
        scan_valid <= 1'b1;
      end

      case (state)
        ST_INIT: begin
          if (init_last) begin
            state <= ST_IDLE;
          end
        end

        // The request type is encoded in the next state, so cpu_we needs
        // no latch of its own.
        ST_IDLE: begin
          if (cpu_req) begin
            lat_addr  <= cpu_addr;
            lat_sel   <= cpu_sel_ram;
            lat_wdata <= cpu_wdata;
            state     <= cpu_we ? ST_RMW_RD : ST_READ;
          end
        end

        ST_READ: begin
          if (slot == SLOT_CPU) begin
            cpu_rdata <= lane_extract(sram_rdata, lat_sel);
            cpu_ready <= 1'b1;
            state     <= ST_ACK;
          end
        end

        ST_RMW_RD: begin
          if (slot == SLOT_CPU) begin
            merge_word <= lane_merge(sram_rdata, lat_wdata, lat_sel);
            state      <= ST_RMW_WR;
          end
        end

        ST_RMW_WR: begin
          if (slot == SLOT_CPU) begin
            cpu_ready <= 1'b1;
            state     <= ST_ACK;
          end
        end

        // cpu_ready is high during this state; a still-asserted cpu_req is
        // only looked at again once back in IDLE.
        ST_ACK: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // SRAM pin mux. Writes and reads are mutually exclusive per cycle, so DQ
  // drive and OE can never overlap.
  // --------------------------------------------------------------------------
  always_comb begin
    sram_addr  = lat_addr;
    sram_wdata = merge_word;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    if (state == ST_INIT) begin
      if (init_we) begin
        sram_addr  = init_addr;
        sram_wdata = init_wdata;
        sram_we_n  = 1'b0;
      end
    end else if (slot == SLOT_SCAN) begin
      sram_addr = scan_addr;
      sram_oe_n = 1'b0;
    end else begin
      case (state)
        ST_READ, ST_RMW_RD: sram_oe_n = 1'b0;
        ST_RMW_WR:          sram_we_n = 1'b0;
        default:            sram_oe_n = 1'b1;
      endcase
    end
  end

  assign sram_drive = ~sram_we_n;
  assign sram_ce_n  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for sram_arbiter with a 16-word SRAM model and a
// registered ROM model (word k = 48'h1111_0000_0000 * k), INIT_WORDS = 4.
// Expected SRAM writes and CPU read data are queued when stimulus is driven
// and compared when the DUT produces them.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  localparam int AW = 20;
  localparam int DW = 48;
  localparam int IW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_sel_ram;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic [AW-1:0] scan_addr;
  logic [15:0]   scan_data;
  logic          scan_valid;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          init_done;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_drive;
  logic [DW-1:0] sram_rdata;
  logic          sram_ce_n, sram_oe_n, sram_we_n;

  int tests = 0;
  int fails = 0;
  int ready_cnt = 0;
  int pin_err = 0;
  int scan_err = 0;
  bit mon_en = 1'b0;

  wr_t         exp_wr_q[$];
  logic [31:0] exp_rd_q[$];

  logic [DW-1:0] mem [0:15];

  always #5 clk = ~clk;

  sram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .INIT_WORDS(IW)
  ) dut (
    .clk_50mhz(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sel_ram(cpu_sel_ram),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .scan_addr(scan_addr), .scan_data(scan_data), .scan_valid(scan_valid),
    .rom_addr(rom_addr), .rom_data(rom_data), .init_done(init_done),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_drive(sram_drive),
    .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  // Asynchronous SRAM model and 1-cycle ROM model.
  assign sram_rdata = mem[sram_addr[3:0]];
  always @(posedge clk) if (sram_we_n === 1'b0) mem[sram_addr[3:0]] = sram_wdata;
  always @(posedge clk) rom_data <= 48'h1111_0000_0000 * {28'd0, rom_addr};

  // Ready pulses counted at posedge; tasks read the count at negedge.
  always @(posedge clk) if (mon_en && cpu_ready === 1'b1) ready_cnt++;

  // Write scoreboard.
  always @(negedge clk) begin : wr_mon
    wr_t e;
    if (mon_en && sram_we_n === 1'b0) begin
      tests++;
      if (exp_wr_q.size() == 0) begin
        fails++;
        $display("FAIL sram_write unexpected: addr=%h data=%h required=no write", sram_addr, sram_wdata);
      end else begin
        e = exp_wr_q.pop_front();
        if (sram_addr !== e.addr || sram_wdata !== e.data) begin
          fails++;
          $display("FAIL sram_write: addr=%h data=%h required addr=%h data=%h",
                   sram_addr, sram_wdata, e.addr, e.data);
        end
      end
    end
  end

  // Pin rules and scan cadence, accumulated for a final comparison.
  logic sv_prev;
  bit   sv_known = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (sram_drive !== ~sram_we_n || sram_ce_n !== 1'b0 ||
          (sram_drive === 1'b1 && sram_oe_n === 1'b0)) pin_err++;
      if (rst !== 1'b0 || init_done !== 1'b1) begin
        sv_known = 1'b0;
      end else begin
        if (sv_known && scan_valid === sv_prev) scan_err++;
        sv_prev  = scan_valid;
        sv_known = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_access(input logic we, input logic sel, input logic [AW-1:0] addr,
                            input logic [31:0] wdata, input bit hold, input bit chk,
                            input logic want_sv);
    int n;
    int exp_lat;
    logic [31:0] e;
    exp_lat = 0;
    if (chk) begin
      for (int i = 0; i < 3 && scan_valid !== want_sv; i++) step();
      // scan_valid high marks the current cycle as a CPU slot.
      exp_lat = (scan_valid === 1'b1) ? (we ? 5 : 3) : (we ? 4 : 2);
    end
    cpu_req = 1'b1; cpu_we = we; cpu_sel_ram = sel; cpu_addr = addr; cpu_wdata = wdata;
    n = 0;
    do begin
      step();
      n++;
    end while (cpu_ready !== 1'b1 && n < 12);
    tests++;
    if (cpu_ready !== 1'b1) begin
      fails++;
      $display("FAIL cpu_ready_timeout: ready=%b after %0d cycles required=1", cpu_ready, n);
      cpu_req = 1'b0;
      return;
    end
    if (chk) begin
      tests++;
      if (n != exp_lat) begin
        fails++;
        $display("FAIL cpu_latency: got=%0d required=%0d (we=%b)", n, exp_lat, we);
      end
    end
    if (!we) begin
      e = exp_rd_q.pop_front();
      tests++;
      if (cpu_rdata !== e) begin
        fails++;
        $display("FAIL cpu_rdata: got=%h required=%h", cpu_rdata, e);
      end
    end
    if (!hold) begin
      cpu_req = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_sel_ram = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; scan_addr = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    tests += 6;
    if (cpu_ready !== 1'b0 || scan_valid !== 1'b0) begin
      fails++; $display("FAIL reset_pulses: ready=%b valid=%b required=0 0", cpu_ready, scan_valid);
    end
    if (init_done !== 1'b0) begin
      fails++; $display("FAIL reset_init_done: got=%b required=0", init_done);
    end
    if (cpu_rdata !== 32'd0 || scan_data !== 16'd0) begin
      fails++; $display("FAIL reset_data: rdata=%h scan=%h required=0 0", cpu_rdata, scan_data);
    end
    if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin
      fails++; $display("FAIL reset_strobes: we_n=%b oe_n=%b required=1 1", sram_we_n, sram_oe_n);
    end
    if (sram_drive !== 1'b0) begin
      fails++; $display("FAIL reset_drive: got=%b required=0", sram_drive);
    end
    if (rom_addr !== '0) begin
      fails++; $display("FAIL reset_rom_addr: got=%h required=0", rom_addr);
    end
    rst = 1'b0;
  endtask

  // Starts at the negedge of cycle 0 (first cycle after the last reset edge).
  task automatic test_init();
    for (int k = 0; k < IW; k++)
      exp_wr_q.push_back({AW'(k), 48'h1111_0000_0000 * 48'(k)});
    for (int k = 0; k <= IW + 1; k++) begin
      if (k <= IW) begin
        tests++;
        if (rom_addr !== AW'(k)) begin
          fails++; $display("FAIL init_rom_addr: cycle %0d got=%h required=%h", k, rom_addr, k);
        end
      end
      tests += 2;
      if (init_done !== (k == IW + 1)) begin
        fails++; $display("FAIL init_done: cycle %0d got=%b required=%b", k, init_done, k == IW + 1);
      end
      if (scan_valid !== 1'b0) begin
        fails++; $display("FAIL init_scan_valid: cycle %0d got=%b required=0", k, scan_valid);
      end
      if (k <= IW) step();
    end
    tests++;
    if (exp_wr_q.size() != 0) begin
      fails++; $display("FAIL init_writes: %0d outstanding required=0", exp_wr_q.size());
    end
  endtask

  task automatic test_scan();
    logic prev;
    mem[2] = 48'hABCD_1234_5678;
    scan_addr = AW'(2);
    repeat (3) step();
    prev = scan_valid;
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (scan_valid === prev) begin
        fails++; $display("FAIL scan_alternate: got=%b required=%b", scan_valid, ~prev);
      end
      if (scan_valid === 1'b1) begin
        tests++;
        if (scan_data !== 16'hABCD) begin
          fails++; $display("FAIL scan_data: got=%h required=abcd", scan_data);
        end
      end
      prev = scan_valid;
    end
  endtask

  task automatic test_cpu_read();
    exp_rd_q.push_back(32'h1234_5678);
    cpu_access(1'b0, 1'b1, AW'(2), 32'd0, 1'b0, 1'b1, 1'b0);
    exp_rd_q.push_back(32'h0000_ABCD);
    cpu_access(1'b0, 1'b0, AW'(2), 32'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_cpu_write();
    exp_wr_q.push_back({AW'(2), 48'hBEEF_1234_5678});
    cpu_access(1'b1, 1'b0, AW'(2), 32'h0000_BEEF, 1'b0, 1'b1, 1'b0);
    tests++;
    if (mem[2] !== 48'hBEEF_1234_5678) begin
      fails++; $display("FAIL vram_write_word: got=%h required=beef12345678", mem[2]);
    end
    exp_wr_q.push_back({AW'(2), 48'hBEEF_CAFE_F00D});
    cpu_access(1'b1, 1'b1, AW'(2), 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1);
    tests++;
    if (mem[2] !== 48'hBEEF_CAFE_F00D) begin
      fails++; $display("FAIL ram_write_word: got=%h required=beefcafef00d", mem[2]);
    end
    exp_rd_q.push_back(32'hCAFE_F00D);
    cpu_access(1'b0, 1'b1, AW'(2), 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int rc0;
    rc0 = ready_cnt;
    exp_wr_q.push_back({AW'(3), 48'h3333_0000_0001});
    exp_rd_q.push_back(32'h0000_0001);
    cpu_access(1'b1, 1'b1, AW'(3), 32'h0000_0001, 1'b1, 1'b1, 1'b0);
    cpu_access(1'b0, 1'b1, AW'(3), 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (6) step();
    tests += 2;
    if (ready_cnt - rc0 != 2) begin
      fails++; $display("FAIL b2b_ready_count: got=%0d required=2", ready_cnt - rc0);
    end
    if (exp_wr_q.size() != 0) begin
      fails++; $display("FAIL b2b_writes: %0d outstanding required=0", exp_wr_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int n;
    int rc0;
    exp_wr_q.push_back({AW'(1), 48'h1234_0000_0000});
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_sel_ram = 1'b0; cpu_addr = AW'(1); cpu_wdata = 32'h0000_1234;
    n = 0;
    while (sram_we_n !== 1'b0 && n < 12) begin
      step();
      n++;
    end
    tests++;
    if (sram_we_n !== 1'b0) begin
      fails++; $display("FAIL midrst_write_seen: we_n=%b required=0", sram_we_n);
    end
    rc0 = ready_cnt;
    rst = 1'b1;
    cpu_req = 1'b0;
    step();
    tests += 4;
    if (sram_we_n !== 1'b1 || sram_drive !== 1'b0) begin
      fails++; $display("FAIL midrst_we_n: we_n=%b drive=%b required=1 0", sram_we_n, sram_drive);
    end
    if (rom_addr !== '0) begin
      fails++; $display("FAIL midrst_rom_addr: got=%h required=0", rom_addr);
    end
    if (init_done !== 1'b0) begin
      fails++; $display("FAIL midrst_init_done: got=%b required=0", init_done);
    end
    if (cpu_ready !== 1'b0) begin
      fails++; $display("FAIL midrst_ready: got=%b required=0", cpu_ready);
    end
    rst = 1'b0;
    test_init();
    step();
    tests++;
    if (ready_cnt != rc0) begin
      fails++; $display("FAIL midrst_no_ready: pulses=%0d required=0", ready_cnt - rc0);
    end
  endtask

  task automatic test_monitors();
    tests += 2;
    if (pin_err != 0) begin
      fails++; $display("FAIL pin_rules: violations=%0d required=0", pin_err);
    end
    if (scan_err != 0) begin
      fails++; $display("FAIL scan_cadence: gaps=%0d required=0", scan_err);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_scan();
    test_cpu_read();
    test_cpu_write();
    test_back_to_back();
    test_mid_reset();
    test_monitors();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Time-slotted controller that shares the single 48-bit asynchronous external SRAM between three masters: a power-up loader copying a synchronous ROM image into SRAM, the VGA scan port reading the 16-bit VRAM lane (bits 47:32), and the CPU port reading or writing either the 32-bit RAM lane (bits 31:0) or the VRAM lane. It sits between the memory-mapped I/O bus and the top-level SRAM pads. Every CPU lane write is performed as a read-modify-write so the other lane is preserved. The top level owns the tristate buffer on SRAM_DQ.

## Interface
- ADDR_W, 20, SRAM word address width
- DATA_W, 48, SRAM data width; the lane split is fixed at 47:32 / 31:0
- INIT_WORDS, 307200, number of ROM words copied at power-up (640x480)
- clk_50mhz  in  1  sole clock
- rst  in  1  reset; synchronous, active-high
- cpu_req  in  1  CPU access request; held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_sel_ram  in  1  1 = RAM lane [31:0], 0 = VRAM lane [47:32]
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  32  write data; only [15:0] used for the VRAM lane
- cpu_rdata  out  32  read data; VRAM lane is zero-extended
- cpu_ready  out  1  one-cycle completion pulse
- scan_addr  in  ADDR_W  VGA scan address
- scan_data  out  16  VRAM lane of the last scan read
- scan_valid  out  1  pulse when scan_data is updated
- rom_addr  out  ADDR_W  init ROM address; ROM has 1-cycle read latency
- rom_data  in  DATA_W  init ROM data
- init_done  out  1  high once the loader has finished
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  data driven onto DQ
- sram_drive  out  1  DQ output enable for the top-level tristate; equals ~sram_we_n
- sram_rdata  in  DATA_W  DQ sampled value
- sram_ce_n / sram_oe_n / sram_we_n  out  1 each  active-low chip enable, output enable and write enable; sram_ce_n is tied 0

## Operation
- **slot register:**
  - toggles every cycle after init; 0 = scan slot, 1 = CPU slot.
  - Held at 0 during INIT.
- **States:** INIT, IDLE, READ, RMW_RD, RMW_WR, ACK.
- **INIT (loader):**
  - Counter c increments every cycle, starting at 0.
  - rom_addr = c.
  - For c >= 1, write rom_data to sram_addr = c-1.
  - After the write to address INIT_WORDS-1: init_done rises, go to IDLE.
  - During INIT: scan_valid stays 0 and cpu_req is ignored.
- **Scan slot (any state after INIT):**
  - Drives a read: sram_addr = scan_addr, sram_oe_n = 0.
  - At the edge ending the slot: scan_data <= sram_rdata[47:32] and scan_valid = 1.
- **IDLE:**
  - cpu_req = 1 latches addr, we, sel and wdata.
  - Next state: READ if read, RMW_RD if write.
  - Acceptance does not depend on slot.
- **READ:**
  - Acts only in a CPU slot: drives a read of the latched address.
  - At the slot end: cpu_rdata <= sel ? rdata[31:0] : {16'b0, rdata[47:32]}; go to ACK.
- **RMW_RD:**
  - In a CPU slot, reads the word and captures the merge register.
  - sel = 1: {old[47:32], wdata[31:0]}.
  - sel = 0: {wdata[15:0], old[31:0]}.
  - Then go to RMW_WR.
- **RMW_WR:** in the next CPU slot, drives sram_we_n = 0 with the merged word; go to ACK.
- **ACK:** cpu_ready = 1 for one cycle, then IDLE. A cpu_req still high during ACK is not re-accepted until IDLE.
- **SRAM pin rules:**
  - Outside write cycles: sram_we_n = 1 and sram_drive = 0.
  - sram_oe_n = 0 only in read cycles.
  - Never drive DQ and OE in the same cycle.

## Timing
- **Reset values:**
  - State INIT, c = 0, slot = 0.
  - cpu_rdata = 0, scan_data = 0, cpu_ready = 0, scan_valid = 0, init_done = 0.
  - sram_we_n = 1, sram_oe_n = 1, sram_drive = 0, rom_addr = 0.
- **Reset mid-operation:** abandons any CPU access with no ready pulse and re-runs init from address 0.
- **Init length:** INIT_WORDS+1 cycles after reset deasserts; init_done is registered.
- **Read latency:** accept edge -> cpu_ready is 2 cycles if the next cycle is a CPU slot, otherwise 3.
- **Write latency:** accept edge -> cpu_ready is 4 or 5 cycles.
- **Scan rate:** one scan read every 2 cycles (25 MHz equivalent); scan_valid lands on alternate cycles with no gaps.
- **Address sampling:** scan_addr is sampled combinationally during the scan slot; CPU address/data are sampled only at accept.
- **Wrap-around:** address arithmetic is ADDR_W bits; c never exceeds INIT_WORDS.

## Structure
- **Package sram_arb_pkg:**
  - state enum
  - SLOT_SCAN / SLOT_CPU constants
  - lane bit-range constants
  - lane merge and extract functions
- **Sub-module sram_init_loader:**
  - Owns counter c, rom_addr, the init write address/data and init_done.
  - The arbiter muxes its outputs onto the SRAM while in INIT.

## Test plan
- **Init:** INIT_WORDS = 4, ROM word k = 48'h1111_0000_0000*k. Required:
  - Writes to addresses 0..3 with those values.
  - init_done high at cycle 5.
  - No scan_valid before init_done.
- **Scan:** after init, scan_addr = 2 with the SRAM model holding 48'hABCD_1234_5678 -> scan_data = 16'hABCD, scan_valid on alternating cycles.
- **CPU RAM-lane read:** same word, sel = 1 -> cpu_rdata = 32'h1234_5678; ready within 3 cycles; scan reads continue unbroken.
- **CPU VRAM-lane write:** wdata = 32'h0000_BEEF, sel = 0, addr = 2 -> SRAM word = 48'hBEEF_1234_5678. Then a RAM-lane write of 32'hCAFE_F00D -> 48'hBEEF_CAFE_F00D.
- **Back-to-back:** cpu_req held high across two requests -> exactly one cpu_ready per access and no double write.
- **Mid-write reset:** assert rst during RMW_WR -> no cpu_ready, sram_we_n = 1 the next cycle, init restarts at rom_addr = 0.
